serial_addsub16: RTL and testbench

//  Bit-serial WIDTH-bit add/subtract unit for the multicycle datapath.

---
 rtl/serial_addsub16_pkg.sv | 18 +
 rtl/serial_addsub16_if.sv | 37 +++
 rtl/serial_addsub16_fa_bit.sv | 21 ++
 rtl/serial_addsub16.sv | 130 +++++++++++++
 tb/tb_serial_addsub16.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub16_pkg.sv
// +-----------------------------------------------------------------------+
// | serial_addsub16_pkg                                                   |
// | Shared state encodings and default width for the serial add/sub unit. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package serial_addsub16_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_addsub16_if.sv
// +-----------------------------------------------------------------------+
// | serial_addsub16_if                                                    |
// | Request/result bundle; ovf exists only with SERIAL_ADDSUB_OVF_EN.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface serial_addsub16_if
  import serial_addsub16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b,
                  input  ready, busy, done, result, cout, ovf);
  modport slave  (input  start, sub, a, b,
                  output ready, busy, done, result, cout, ovf);
`else
  modport master (output start, sub, a, b,
                  input  ready, busy, done, result, cout);
  modport slave  (input  start, sub, a, b,
                  output ready, busy, done, result, cout);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_addsub16_fa_bit.sv
// +-----------------------------------------------------------------------+
// | fa_bit                                                                |
// | One-bit full adder cell shared by every bit position of the op.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module fa_bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_addsub16.sv
// +-----------------------------------------------------------------------+
// | serial_addsub16                                                       |
// | Bit-serial add/subtract, LSB first, one bit per clock.                |
// | Option: SERIAL_ADDSUB_OVF_EN adds signed-overflow output ovf.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module serial_addsub16
  import serial_addsub16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input wire logic         clk,
  input wire logic         rst_n,
  serial_addsub16_if.slave bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-2:0] r_sum;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_s;
  logic             w_c;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;

  fa_bit u_fa (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_accept   = w_ready & bus.start;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum_next = {w_s, r_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_RUN:  w_busy  = 1'b1;
      ST_DONE: begin
        w_ready = 1'b1;
        w_done  = 1'b1;
      end
      default: w_ready = 1'b0;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on accept and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= bus.a;
      r_opb   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (r_state == ST_RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_c;
      r_sum   <= w_sum_next[WIDTH-1:1];
      if (w_last) begin
        r_result <= w_sum_next;
        r_cout   <= w_c;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;

  // On the last bit r_carry is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 1'b0;
    else if (r_state == ST_RUN && w_last)  r_ovf <= r_carry ^ w_c;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.ready  = w_ready;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub16.sv
// +-----------------------------------------------------------------------+
// | tb_serial_addsub16                                                    |
// | Table, corner-sequence and random checks against an arithmetic model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_serial_addsub16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_addsub16_if #(.WIDTH(16)) bus ();

  serial_addsub16 #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, cout = no-borrow for sub.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] res, output logic c, output logic v);
    int sa;
    int sb;
    int sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      res = a - b;
      c   = (a >= b);
      sr  = sa - sb;
    end else begin
      res = a + b;
      c   = (int'(a) + int'(b)) > 65535;
      sr  = sa + sb;
    end
    v = (sr > 32767) || (sr < -32768);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input bit at_neg);
    if (at_neg) @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 40);
  endtask

  task automatic check_outputs(input string name, input logic [15:0] res,
                               input logic c, input logic v);
    check({name, ".result"}, 32'(bus.result), 32'(res));
    check({name, ".cout"},   32'(bus.cout),   32'(c));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({name, ".ovf"},    32'(bus.ovf),    32'(v));
`else
    if (v === 1'bx) check({name, ".ovf_x"}, 32'(v), 32'(0));
`endif
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input bit at_neg);
    int          lat;
    logic [15:0] er;
    logic        ec;
    logic        ev;
    model(a, b, sub, er, ec, ev);
    issue(a, b, sub, at_neg);
    wait_done(lat);
    check({name, ".latency"}, 32'(lat), 32'd16);
    check({name, ".ready_in_done"}, 32'(bus.ready), 32'd1);
    check_outputs(name, er, ec, ev);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [15:0] er;
    logic        ec;
    logic        ev;

    total = 0;
    bad   = 0;
    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready",  32'(bus.ready),  32'd1);
    check("reset.busy",   32'(bus.busy),   32'd0);
    check("reset.done",   32'(bus.done),   32'd0);
    check_outputs("reset", 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1);
      wait_done(lat);
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'd16);
      check_outputs($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.done_one_cycle", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d.held", i), 32'(bus.result), 32'(vecs[i].res));
    end

    // start pulses during RUN are ignored; result held until completion
    issue(16'h1111, 16'h2222, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("ignore.busy", 32'(bus.busy), 32'd1);
    check("ignore.held_mid_run", 32'(bus.result), 32'h5555);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    bus.a = 16'h0F0F; bus.b = 16'hF0F0; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done(lat);
    check("ignore.latency", 32'(lat + 11), 32'd16);
    check_outputs("ignore", 16'h3333, 1'b0, 1'b0);

    // Back-to-back start issued while in DONE
    do_op("b2b", 16'h00FF, 16'h0F0F, 1'b1, 1'b0);
    do_op("b2b2", 16'h4000, 16'h4000, 1'b0, 1'b0);

    // Reset in the middle of RUN
    do_op("pre_rst", 16'hFFFF, 16'h0002, 1'b0, 1'b1);
    issue(16'h0100, 16'h0200, 1'b0, 1'b1);
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.ready", 32'(bus.ready), 32'd1);
    check("midrst.busy",  32'(bus.busy),  32'd0);
    check("midrst.done",  32'(bus.done),  32'd0);
    check_outputs("midrst", 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("midrst.no_done", 32'(seen), 32'd0);
    do_op("post_rst", 16'hABCD, 16'h1234, 1'b0, 1'b1);

    // Randomised operations, some issued back-to-back from DONE
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000 | 16'($urandom_range(0, 3));
      model(ra, rb, rs, er, ec, ev);
      do_op($sformatf("rand%0d", i), ra, rb, rs, (i % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
